// File: rtl/fifo_xfer_pkg.sv
// Shared definitions for the ROM -> DCFIFO -> RAM transfer path. Used by both
// the transmit-side write controller and the receive-side drain controller.
package fifo_xfer_pkg;

    localparam int XFER_DATA_W    = 32;
    localparam int XFER_ADDR_W    = 8;
    localparam int XFER_NUM_WORDS = 256;
    localparam int XFER_CNT_W     = 9;

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_FLUSH    = 2'd1,
        S_READBACK = 2'd2,
        S_DONE     = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/xfer_addr_counter.sv
// Loadable, enabled up-counter that parks at a terminal value. tc is high
// while the count sits at TERM; further enables are ignored until a load.
module xfer_addr_counter #(
    parameter int W    = 9,
    parameter int TERM = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(TERM));

    // Load wins over count; counting stops once the terminal value is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Receive-domain drain controller: pulls NUM_WORDS words out of a
// non-showahead DCFIFO into a single-port RAM, then sweeps the RAM once in
// read mode and raises a sticky done.
module fifo_drain_ctrl
    import fifo_xfer_pkg::*;
#(
    parameter int DATA_W    = XFER_DATA_W,
    parameter int ADDR_W    = XFER_ADDR_W,
    parameter int NUM_WORDS = XFER_NUM_WORDS,
    parameter int CNT_W     = XFER_CNT_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rdempty_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              rdreq_o,
    output logic              wren_o,
    output logic              rden_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  word_count_o,
    output logic              done_o
);

    xfer_state_e      state, state_nxt;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] rb_cnt;
    logic             issue_tc;
    logic             rb_tc;
    logic             rd_vld;
    logic             last_issue;
    logic             last_write;
    logic             rb_load;
    logic             rb_hi_unused;

    // Requests issued to the FIFO; parks at NUM_WORDS so no extra word is taken.
    xfer_addr_counter #(.W(CNT_W), .TERM(NUM_WORDS)) u_issue_cnt (
        .clk      (clk_i),
        .reset    (reset_i),
        .load     (1'b0),
        .load_val ('0),
        .en       (rdreq_o),
        .count    (issued),
        .tc       (issue_tc)
    );

    // Readback address; cleared on the edge that writes the final word.
    xfer_addr_counter #(.W(CNT_W), .TERM(NUM_WORDS)) u_rb_addr (
        .clk      (clk_i),
        .reset    (reset_i),
        .load     (rb_load),
        .load_val ('0),
        .en       (state == S_READBACK),
        .count    (rb_cnt),
        .tc       (rb_tc)
    );

    // Only the low address bits drive the RAM; the top bit marks sweep end via tc.
    assign rb_hi_unused = ^rb_cnt[CNT_W-1:ADDR_W];

    assign last_issue = rdreq_o && (issued == CNT_W'(NUM_WORDS - 1));
    assign last_write = rd_vld && (word_count_o == CNT_W'(NUM_WORDS - 1));
    assign rb_load    = (state == S_FLUSH) && last_write;

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= S_FILL;
        else         state <= state_nxt;
    end

    // Next state and the combinational FIFO read request. Reset blocks the
    // request so no word is popped and then lost to the reset.
    always_comb begin
        state_nxt = state;
        rdreq_o   = 1'b0;
        unique case (state)
            S_FILL: begin
                rdreq_o = !reset_i && !rdempty_i && !issue_tc;
                if (last_issue) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (last_write) state_nxt = S_READBACK;
            end
            S_READBACK: begin
                if (rb_tc) state_nxt = S_DONE;
            end
            default: state_nxt = S_DONE;
        endcase
    end

    // Write stage during fill/flush, address sweep during readback.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_vld       <= 1'b0;
            wren_o       <= 1'b0;
            rden_o       <= 1'b0;
            addr_o       <= '0;
            data_o       <= '0;
            word_count_o <= '0;
            done_o       <= 1'b0;
        end else begin
            rd_vld <= rdreq_o;
            wren_o <= 1'b0;
            unique case (state)
                S_FILL, S_FLUSH: begin
                    if (rd_vld) begin
                        wren_o       <= 1'b1;
                        data_o       <= data_i;
                        addr_o       <= word_count_o[ADDR_W-1:0];
                        word_count_o <= word_count_o + 1'b1;
                    end
                end
                S_READBACK: begin
                    if (!rb_tc) begin
                        rden_o <= 1'b1;
                        addr_o <= rb_cnt[ADDR_W-1:0];
                    end else begin
                        rden_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: rden_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a FIFO/RAM-level model predicts every output
// each cycle from accepted requests, plus literal checks on latency, counts
// and final values.
module tb_fifo_drain_ctrl;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        rdempty_i = 1'b1;
    logic [31:0] data_i = '0;
    logic        rdreq_o, wren_o, rden_o, done_o;
    logic [7:0]  addr_o;
    logic [31:0] data_o;
    logic [8:0]  word_count_o;

    always #5 clk = ~clk;

    fifo_drain_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .rdempty_i    (rdempty_i),
        .data_i       (data_i),
        .rdreq_o      (rdreq_o),
        .wren_o       (wren_o),
        .rden_o       (rden_o),
        .addr_o       (addr_o),
        .data_o       (data_o),
        .word_count_o (word_count_o),
        .done_o       (done_o)
    );

    typedef struct {
        int          c;
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wq[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, acc = 0, wr = 0, last = -1;
    bit          run = 0, known = 0, pend_v = 0;
    logic [31:0] pend_d = '0, base = '0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          n_rdreq, n_wren, n_rden, first_rdreq, first_wren, phase_cyc;
    logic        exp_rdreq, exp_wren, in_rb, in_done;
    wr_t         ent;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare process: FIFO/RAM transaction model evaluated every cycle.
    always @(negedge clk) begin
        if (run) begin
            exp_rdreq = !reset_i && !rdempty_i && (acc < N);
            chk("rdreq", rdreq_o, exp_rdreq);
            if (known) begin
                exp_wren = (wq.size() > 0) && (wq[0].c == cyc);
                if (exp_wren) begin
                    m_addr = wq[0].a;
                    m_data = wq[0].d;
                    void'(wq.pop_front());
                    wr++;
                    if (wr == N) last = cyc;
                end
                in_rb   = (last >= 0) && (cyc > last) && (cyc <= last + N);
                in_done = (last >= 0) && (cyc > last + N);
                chk("wren", wren_o, exp_wren);
                chk("rden", rden_o, in_rb);
                chk("done", done_o, in_done);
                chk("word_count", word_count_o, wr);
                if (in_rb) chk("rb_addr", addr_o, cyc - last - 1);
                else       chk("addr", addr_o, m_addr);
                if (!in_rb && !in_done) chk("data", data_o, m_data);
            end
            if (rdreq_o) begin
                n_rdreq++;
                if (first_rdreq < 0) first_rdreq = cyc;
            end
            if (wren_o) begin
                n_wren++;
                if (first_wren < 0) first_wren = cyc;
            end
            if (rden_o) n_rden++;
            pend_v = 1'b0;
            if (rdreq_o && !rdempty_i) begin
                ent.c = cyc + 2;
                ent.a = acc[7:0];
                ent.d = base + acc;
                wq.push_back(ent);
                pend_v = 1'b1;
                pend_d = ent.d;
                acc++;
            end
            if (reset_i) begin
                wq.delete();
                acc = 0; wr = 0; last = -1;
                m_addr = '0; m_data = '0;
                pend_v = 1'b0;
                known = 1'b1;
            end
        end
    end

    // One cycle of stimulus; returns after that cycle has been compared.
    task automatic tick(input bit rst, input int mode);
        @(posedge clk);
        #1;
        cyc++;
        run     = 1'b1;
        reset_i = rst;
        case (mode)
            0:       rdempty_i = 1'b0;
            1:       rdempty_i = (((cyc - phase_cyc) % 5) < 3);
            default: rdempty_i = ($urandom_range(0, 99) < 35);
        endcase
        data_i = pend_v ? pend_d : $urandom;
        @(negedge clk);
        #1;
    endtask

    task automatic start_phase(input logic [31:0] b);
        base = b;
        n_rdreq = 0; n_wren = 0; n_rden = 0;
        first_rdreq = -1; first_wren = -1;
        phase_cyc = cyc;
    endtask

    // Run until done has been held 50 cycles; optional reset after rst_at writes.
    task automatic run_to_done(input int mode, input int rst_at);
        int guard;
        bit did_rst;
        guard = 0;
        did_rst = 0;
        while (!((last >= 0) && (cyc >= last + N + 51))) begin
            guard++;
            if (guard > 4000) begin
                checks++;
                errors++;
                $display("FAIL timeout at cycle %0d: done not reached, writes=%0d expected %0d", cyc, wr, N);
                break;
            end
            if (rst_at >= 0 && !did_rst && wr >= rst_at) begin
                tick(1'b1, mode);
                did_rst = 1;
            end else begin
                tick(1'b0, mode);
            end
        end
    endtask

    initial begin
        // Reset with FIFO non-empty, then a streaming fill.
        repeat (3) tick(1'b1, 0);
        chk("rst_word_count", word_count_o, 9'h000);
        chk("rst_addr", addr_o, 8'h00);
        start_phase(32'hA500_0000);
        run_to_done(0, -1);
        chk("lit_first_wr_latency", first_wren - first_rdreq, 2);
        chk("lit_n_rdreq", n_rdreq, 256);
        chk("lit_n_wren", n_wren, 256);
        chk("lit_wr_span", last - first_wren, 255);
        chk("lit_n_rden", n_rden, 256);
        chk("lit_final_count", word_count_o, 9'h100);
        chk("lit_final_addr", addr_o, 8'hFF);
        chk("lit_final_done", done_o, 1'b1);

        // Bubbled fill: 3 empty / 2 non-empty.
        repeat (3) tick(1'b1, 0);
        start_phase(32'h3C00_0000);
        run_to_done(1, -1);
        chk("lit_bub_n_rdreq", n_rdreq, 256);
        chk("lit_bub_n_wren", n_wren, 256);
        chk("lit_bub_n_rden", n_rden, 256);
        chk("lit_bub_count", word_count_o, 9'h100);

        // Random empties with a reset after 100 writes, then a fresh transfer.
        repeat (2) tick(1'b1, 2);
        start_phase(32'h7700_0000);
        run_to_done(2, 100);
        chk("lit_rst_count", word_count_o, 9'h100);
        chk("lit_rst_done", done_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
